cond_logic: RTL



---
 rtl/cond_pkg.sv | 30 +++
 rtl/cond_check.sv | 47 ++++
 rtl/cond_logic.sv | 90 +++++++++
 3 files changed

// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution logic.
//   cond_e  : ARM condition-field encodings (bits [31:28] of an instruction)
//   FLAG_*  : bit positions of N, Z, C, V inside a 4-bit {N,Z,C,V} flag vector
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition evaluator: decides whether an instruction
// with condition field `cond` executes, given the stored flags.
//   cond    in  [3:0]  instruction condition field
//   flags   in  [3:0]  stored {N,Z,C,V}
//   cond_ex out        1 when the condition passes
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        case (cond_e'(cond))
            EQ: cond_ex = z;
            NE: cond_ex = ~z;
            CS: cond_ex = c;
            CC: cond_ex = ~c;
            MI: cond_ex = n;
            PL: cond_ex = ~n;
            VS: cond_ex = v;
            VC: cond_ex = ~v;
            HI: cond_ex = c & ~z;
            LS: cond_ex = ~c | z;
            GE: cond_ex = (n == v);
            LT: cond_ex = (n != v);
            GT: cond_ex = ~z & (n == v);
            LE: cond_ex = z | (n != v);
            AL: cond_ex = 1'b1;
            // The unconditional-extension space is executed like AL here.
            NV: cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit downstream of the ALU. Holds the NZCV flags,
// gates the controller's write requests with the condition result, and
// counts executed and squashed instructions.
//   clk, reset           clock, asynchronous active-high reset
//   InstrValid           instruction is real; qualifies every state update
//   Cond [3:0]           condition field
//   ALUFlags [3:0]       {N,Z,C,V} from the ALU
//   FlagW [1:0]          [1] write N,Z  [0] write C,V
//   PCS, RegW, MemW      decoder write requests
//   NoWrite              compare-class instruction, suppresses RegWrite
//   PCSrc, RegWrite, MemWrite  gated requests (combinational)
//   CondEx               condition result (combinational, not gated by InstrValid)
//   Flags [3:0]          stored {N,Z,C,V}
//   ExecCount, SkipCount [CNT_W-1:0]  wrapping instruction counters
module cond_logic
    import cond_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InstrValid,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SkipCount
);

    logic cond_pass;
    logic issue;
    logic wr_nz;
    logic wr_cv;

    // Condition is judged on the registered flags, so an instruction sees
    // the flags left by its predecessor, never the same-cycle ALU result.
    cond_check u_check (
        .cond    (Cond),
        .flags   (Flags),
        .cond_ex (cond_pass)
    );

    assign CondEx = cond_pass;
    assign issue  = InstrValid & cond_pass;

    assign PCSrc    = issue & PCS;
    assign RegWrite = issue & RegW & ~NoWrite;
    assign MemWrite = issue & MemW;

    assign wr_nz = issue & FlagW[1];
    assign wr_cv = issue & FlagW[0];

    // N,Z and C,V halves load independently so logical ops can leave C,V intact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Flags <= 4'b0000;
        end else begin
            if (wr_nz) begin
                Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
            end
            if (wr_cv) begin
                Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
            end
        end
    end

    // Exactly one counter advances per valid instruction; both wrap freely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ExecCount <= '0;
            SkipCount <= '0;
        end else if (InstrValid) begin
            if (cond_pass) begin
                ExecCount <= ExecCount + CNT_W'(1);
            end else begin
                SkipCount <= SkipCount + CNT_W'(1);
            end
        end
    end

endmodule
